// File: rtl/uart_led_cmd_ctrl_pkg.sv
// Purpose: shared opcodes, response codes and FSM state types for the
//          UART LED command controller.
// Ports:   none (package).
package uart_led_cmd_ctrl_pkg;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_WR_FULL  = 4'h5;
    localparam logic [3:0] OP_READ     = 4'h6;
    localparam logic [3:0] OP_CLEAR    = 4'h7;

    // Low nibble of the NAK sent when a multi-byte command stalls.
    localparam logic [3:0] NAK_TIMEOUT = 4'hE;

    typedef enum logic {
        R_IDLE,
        R_COLLECT
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_WAIT_HI,
        T_WAIT_LO
    } tx_state_t;

    // Number of whole bytes needed to carry a w-bit LED value.
    function automatic int unsigned bytes_for(input int unsigned w);
        return (w + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/uart_led_cmd_ctrl_if.sv
// Purpose: byte-level handshake between the UART receiver/transmitter and the
//          command controller.
// Signals: cs (active-low select), rx_data/rx_valid (received byte strobe),
//          tx_busy (transmitter busy), tx_data/tx_start (byte + start pulse).
interface uart_led_cmd_ctrl_if;

    logic       cs;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;

    // UART side: supplies received bytes and transmitter status.
    modport master (
        output cs, rx_data, rx_valid, tx_busy,
        input  tx_data, tx_start
    );

    // Controller side.
    modport slave (
        input  cs, rx_data, rx_valid, tx_busy,
        output tx_data, tx_start
    );

endinterface

// File: rtl/uart_led_cmd_ctrl_resp_fifo.sv
// Purpose: synchronous response FIFO with a multi-entry write port and a
//          single-entry read port.
// Ports:   clk, reset (sync, active-high)
//          wr_cnt  - number of entries to push this cycle (0..WR_W)
//          wr_data - entries to push, entry 0 first
//          rd_en   - pop head (ignored when empty)
//          rd_data_c, empty_c, free_c - combinational head/status
module uart_led_cmd_ctrl_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WR_W  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(DEPTH):0]       wr_cnt,
    input  logic [WR_W-1:0][7:0]         wr_data,
    input  logic                         rd_en,
    output logic [7:0]                   rd_data_c,
    output logic                         empty_c,
    output logic [$clog2(DEPTH):0]       free_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;

    assign empty_c   = (count_q == '0);
    assign free_c    = CW'(DEPTH) - count_q;
    assign rd_data_c = mem_q[rd_ptr_q];
    assign pop       = rd_en & ~empty_c;

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_cnt);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + wr_cnt - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WR_W; i++) begin
            if (CW'(i) < wr_cnt) begin
                mem_q[AW'(wr_ptr_q + AW'(i))] <= wr_data[i];
            end
        end
    end

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// Purpose: decodes LED commands from a UART byte stream, maintains the LED
//          register and returns ACK/NAK/readback bytes through a response FIFO
//          drained by a start/busy transmit handshake.
// Ports:   clk, reset (sync, active-high)
//          bus    - UART handshake (cs, rx_data, rx_valid, tx_busy, tx_data, tx_start)
//          led    - LED register
//          cs_mon - cs delayed by one cycle
//          ovf    - sticky flag: a command was dropped for lack of FIFO space
module uart_led_cmd_ctrl
    import uart_led_cmd_ctrl_pkg::*;
#(
    parameter int unsigned LED_W       = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [3:0]  ACK_TAG     = 4'hA,
    parameter logic [3:0]  NAK_TAG     = 4'h5,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_led_cmd_ctrl_if.slave   bus,
    output logic [LED_W-1:0]     led,
    output logic                 cs_mon,
    output logic                 ovf
);

    localparam int unsigned NB   = bytes_for(LED_W);
    localparam int unsigned SW   = NB * 8;
    localparam int unsigned WR_W = NB + 1;
    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BW   = $clog2(NB + 1);

    rx_state_t        rx_state_q, rx_state_d;
    tx_state_t        tx_state_q, tx_state_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [SW-1:0]    shadow_q, shadow_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             ovf_q, ovf_d;
    logic             cs_mon_q;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;

    logic [CW-1:0]        wr_cnt;
    logic [WR_W-1:0][7:0] wr_data;
    logic                 rd_en;
    logic [7:0]           rd_data_c;
    logic                 empty_c;
    logic [CW-1:0]        free_c;

    logic             accept;
    logic [3:0]       op;
    logic [3:0]       arg;
    logic [1:0]       nib_k;
    logic             nib_ok;
    logic [15:0]      nib_pad;
    logic [SW-1:0]    sh;
    logic [SW-1:0]    rd_pad;
    logic             want_push;
    logic             want_read;
    logic [7:0]       resp;
    logic             led_en;
    logic [LED_W-1:0] led_new;

    uart_led_cmd_ctrl_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WR_W  (WR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_cnt    (wr_cnt),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data_c (rd_data_c),
        .empty_c   (empty_c),
        .free_c    (free_c)
    );

    assign accept = bus.rx_valid & ~bus.cs;
    assign op     = bus.rx_data[7:4];
    assign arg    = bus.rx_data[3:0];
    assign nib_k  = 2'(op - 4'd1);
    // Nibbles that start at or beyond LED_W are rejected.
    assign nib_ok = (int'(nib_k) * 4) < int'(LED_W);

    // RX decode, collection FSM and response generation.
    always_comb begin
        rx_state_d = rx_state_q;
        led_d      = led_q;
        shadow_d   = shadow_q;
        bcnt_d     = bcnt_q;
        timer_d    = timer_q;
        ovf_d      = ovf_q;
        wr_cnt     = '0;
        wr_data    = '0;
        want_push  = 1'b0;
        want_read  = 1'b0;
        resp       = 8'h00;
        led_en     = 1'b0;
        led_new    = led_q;
        sh         = shadow_q;
        rd_pad     = SW'(led_q);
        nib_pad    = 16'(led_q);
        nib_pad[{nib_k, 2'b00} +: 4] = arg;

        case (rx_state_q)
            R_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_NOP: begin
                            want_push = 1'b1;
                            resp      = {ACK_TAG, arg};
                        end
                        4'h1, 4'h2, 4'h3, 4'h4: begin
                            want_push = 1'b1;
                            if (nib_ok) begin
                                resp    = {ACK_TAG, arg};
                                led_en  = 1'b1;
                                led_new = LED_W'(nib_pad);
                            end else begin
                                resp    = {NAK_TAG, op};
                            end
                        end
                        OP_WR_FULL: begin
                            rx_state_d = R_COLLECT;
                            bcnt_d     = '0;
                            timer_d    = '0;
                            shadow_d   = '0;
                        end
                        OP_READ: begin
                            want_read = 1'b1;
                        end
                        OP_CLEAR: begin
                            want_push = 1'b1;
                            resp      = {ACK_TAG, OP_CLEAR};
                            led_en    = 1'b1;
                            led_new   = '0;
                        end
                        default: begin
                            want_push = 1'b1;
                            resp      = {NAK_TAG, op};
                        end
                    endcase
                end
            end
            R_COLLECT: begin
                if (bus.cs) begin
                    // Deselect abandons the command without a response.
                    rx_state_d = R_IDLE;
                end else if (accept) begin
                    sh[{bcnt_q, 3'b000} +: 8] = bus.rx_data;
                    shadow_d = sh;
                    timer_d  = '0;
                    bcnt_d   = bcnt_q + BW'(1);
                    if (bcnt_q == BW'(NB - 1)) begin
                        rx_state_d = R_IDLE;
                        want_push  = 1'b1;
                        resp       = {ACK_TAG, OP_WR_FULL};
                        led_en     = 1'b1;
                        led_new    = LED_W'(sh);
                    end
                end else if (timer_q == TW'(TIMEOUT_CYC)) begin
                    rx_state_d = R_IDLE;
                    want_push  = 1'b1;
                    resp       = {NAK_TAG, NAK_TIMEOUT};
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: rx_state_d = R_IDLE;
        endcase

        // Space check uses the pre-pop free count; a refused command has no effect.
        if (want_push) begin
            if (free_c >= CW'(1)) begin
                wr_cnt     = CW'(1);
                wr_data[0] = resp;
                if (led_en) begin
                    led_d = led_new;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (want_read) begin
            if (free_c >= CW'(WR_W)) begin
                wr_cnt     = CW'(WR_W);
                wr_data[0] = {ACK_TAG, OP_READ};
                for (int unsigned i = 0; i < NB; i++) begin
                    wr_data[i + 1] = rd_pad[i * 8 +: 8];
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // TX FSM: pop one byte, pulse start, then track one busy high/low cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        rd_en      = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (!empty_c) begin
                    rd_en      = 1'b1;
                    tx_data_d  = rd_data_c;
                    tx_start_d = 1'b1;
                    tx_state_d = T_START;
                end
            end
            T_START:   tx_state_d = T_WAIT_HI;
            T_WAIT_HI: if (bus.tx_busy)  tx_state_d = T_WAIT_LO;
            T_WAIT_LO: if (!bus.tx_busy) tx_state_d = T_IDLE;
            default:   tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= R_IDLE;
            tx_state_q <= T_IDLE;
            led_q      <= '0;
            shadow_q   <= '0;
            bcnt_q     <= '0;
            timer_q    <= '0;
            ovf_q      <= 1'b0;
            cs_mon_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            led_q      <= led_d;
            shadow_q   <= shadow_d;
            bcnt_q     <= bcnt_d;
            timer_q    <= timer_d;
            ovf_q      <= ovf_d;
            cs_mon_q   <= bus.cs;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign led          = led_q;
    assign cs_mon       = cs_mon_q;
    assign ovf          = ovf_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// Purpose: directed self-checking bench for uart_led_cmd_ctrl (LED_W=8,
//          FIFO_DEPTH=4, TIMEOUT_CYC=100).
module tb_uart_led_cmd_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] led;
    logic       cs_mon;
    logic       ovf;

    int total;
    int bad;

    uart_led_cmd_ctrl_if dif ();

    uart_led_cmd_ctrl #(
        .LED_W       (8),
        .FIFO_DEPTH  (4),
        .ACK_TAG     (4'hA),
        .NAK_TAG     (4'h5),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (dif),
        .led    (led),
        .cs_mon (cs_mon),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        dif.rx_data  = b;
        dif.rx_valid = 1'b1;
        @(negedge clk);
        dif.rx_valid = 1'b0;
    endtask

    // Wait for a start pulse, check its byte and that it lasts one cycle.
    task automatic wait_start(input logic [7:0] exp, input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 400) begin
            if (dif.tx_start === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk(32'(seen), 32'd1, {tag, "_start"});
        chk(32'(dif.tx_data), 32'(exp), {tag, "_data"});
        @(negedge clk);
        chk(32'(dif.tx_start), 32'd0, {tag, "_pulse"});
    endtask

    // Full transmit: start pulse, then a busy high/low cycle from the bench.
    task automatic expect_tx(input logic [7:0] exp, input string tag);
        wait_start(exp, tag);
        dif.tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk(32'(dif.tx_data), 32'(exp), {tag, "_hold"});
        dif.tx_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic no_tx(input int cycles, input string tag);
        int cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (dif.tx_start === 1'b1) cnt++;
        end
        chk(32'(cnt), 32'd0, tag);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        dif.cs       = 1'b1;
        dif.rx_data  = 8'h00;
        dif.rx_valid = 1'b0;
        dif.tx_busy  = 1'b0;

        repeat (3) @(negedge clk);
        chk(32'(led), 32'h00, "rst_led");
        chk(32'(dif.tx_start), 32'd0, "rst_start");
        chk(32'(dif.tx_data), 32'h00, "rst_txdata");
        chk(32'(cs_mon), 32'd0, "rst_csmon");
        chk(32'(ovf), 32'd0, "rst_ovf");
        reset = 1'b0;
        @(negedge clk);
        chk(32'(cs_mon), 32'd1, "csmon_high");
        dif.cs = 1'b0;
        @(negedge clk);
        chk(32'(cs_mon), 32'd0, "csmon_low");

        // Nibble write to the low nibble.
        send_byte(8'h13);
        chk(32'(led), 32'h03, "wrnib0_led");
        expect_tx(8'hA3, "wrnib0_ack");

        // Full write commits only after the data byte.
        send_byte(8'h56);
        chk(32'(led), 32'h03, "wrfull_pending");
        send_byte(8'h12);
        chk(32'(led), 32'h12, "wrfull_led");
        expect_tx(8'hA5, "wrfull_ack");
        no_tx(20, "wrfull_single");

        // Full write that stalls until timeout.
        send_byte(8'h50);
        expect_tx(8'h5E, "timeout_nak");
        chk(32'(led), 32'h12, "timeout_led");

        // Build 0x3C nibble by nibble, then read back.
        send_byte(8'h1C);
        chk(32'(led), 32'h1C, "wrnib0b_led");
        expect_tx(8'hAC, "wrnib0b_ack");
        send_byte(8'h23);
        chk(32'(led), 32'h3C, "wrnib1_led");
        expect_tx(8'hA3, "wrnib1_ack");
        send_byte(8'h60);
        expect_tx(8'hA6, "read_ack");
        expect_tx(8'h3C, "read_byte");

        // Nibbles beyond an 8-bit LED are refused.
        send_byte(8'h35);
        expect_tx(8'h53, "wrnib2_nak");
        send_byte(8'h47);
        expect_tx(8'h54, "wrnib3_nak");
        chk(32'(led), 32'h3C, "nak_led");

        // Overflow: one byte in flight, four queued, the sixth NOP dropped.
        dif.tx_busy = 1'b1;
        send_byte(8'h01);
        wait_start(8'hA1, "ovf_first");
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h05);
        chk(32'(ovf), 32'd0, "ovf_full_ok");
        send_byte(8'h06);
        chk(32'(ovf), 32'd1, "ovf_set");
        dif.tx_busy = 1'b0;
        expect_tx(8'hA2, "ovf_q0");
        expect_tx(8'hA3, "ovf_q1");
        expect_tx(8'hA4, "ovf_q2");
        expect_tx(8'hA5, "ovf_q3");
        no_tx(20, "ovf_drained");
        chk(32'(ovf), 32'd1, "ovf_sticky");

        // Deselect during a full write aborts silently.
        send_byte(8'h50);
        @(negedge clk);
        dif.cs = 1'b1;
        repeat (2) @(negedge clk);
        dif.cs = 1'b0;
        no_tx(150, "abort_silent");
        chk(32'(led), 32'h3C, "abort_led");

        // Unknown opcode, then a byte while deselected.
        send_byte(8'h9F);
        expect_tx(8'h59, "badop_nak");
        dif.cs = 1'b1;
        send_byte(8'h12);
        chk(32'(led), 32'h3C, "cs_ignored_led");
        chk(32'(cs_mon), 32'd1, "cs_ignored_mon");
        no_tx(20, "cs_ignored_tx");
        dif.cs = 1'b0;
        @(negedge clk);

        // Clear and a plain NOP.
        send_byte(8'h70);
        chk(32'(led), 32'h00, "clear_led");
        expect_tx(8'hA7, "clear_ack");
        send_byte(8'h0B);
        expect_tx(8'hAB, "nop_ack");

        // Reset while waiting for busy to rise, with bytes still queued.
        send_byte(8'h11);
        wait_start(8'hA1, "rst_mid_first");
        send_byte(8'h02);
        send_byte(8'h03);
        chk(32'(led), 32'h01, "rst_mid_led_pre");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk(32'(dif.tx_start), 32'd0, "rst_mid_start");
        chk(32'(dif.tx_data), 32'h00, "rst_mid_txdata");
        chk(32'(led), 32'h00, "rst_mid_led");
        chk(32'(ovf), 32'd0, "rst_mid_ovf");
        reset = 1'b0;
        no_tx(20, "rst_mid_empty");

        send_byte(8'h13);
        chk(32'(led), 32'h03, "post_rst_led");
        expect_tx(8'hA3, "post_rst_ack");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
